pool2x2_stream: RTL and testbench

Streaming 2x2/stride-2 pooling stage for the CNN datapath, placed after the convolution engine. It is the successor to the buffered 30x30 max-pool stage. It accepts one signed pixel per handshake in raster order and emits pooled results as soon as each window completes. It holds only one row of partial results, not a full frame. It adds runtime max/average mode selection, valid/ready back-pressure, and parametrised width and frame size.

---
 rtl/npu_pool_pkg.sv | 13 +
 rtl/pool_line_buffer.sv | 18 +
 rtl/pool2x2_stream.sv | 92 +++++++++
 tb/tb_pool2x2_stream.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/npu_pool_pkg.sv
// npu_pool_pkg: shared types and the max/add operator for the 2x2 pooling stage
package npu_pool_pkg;
  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} pool_state_e;
  localparam int POOL_CW = 40;
  function automatic logic signed [POOL_CW-1:0] pool_combine(
    input pool_mode_e mode,
    input logic signed [POOL_CW-1:0] a,
    input logic signed [POOL_CW-1:0] b
  );
    return mode == POOL_AVG ? a + b : (a > b ? a : b);
  endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one row of horizontal pair results, unreset so it maps to distributed RAM
module pool_line_buffer #(
  parameter int DEPTH = 15,
  parameter int WIDTH = 23,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2/stride-2 max/average pooling with valid/ready handshakes
module pool2x2_stream
  import npu_pool_pkg::*;
#(
  parameter int DATA_W = 22,
  parameter int IMG_W = 30,
  parameter int IMG_H = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int DEPTH = IMG_W / 2;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  pool_state_e state, state_d;
  pool_mode_e mode_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic in_done;
  logic [DATA_W-1:0] hold;
  logic [DATA_W:0] pair, lb_rd;
  logic signed [POOL_CW-1:0] vsum;
  logic accept, x_last, y_last, emit;

  assign in_ready = state == RUN && !in_done && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign x_last = x == XW'(IMG_W - 1);
  assign y_last = y == YW'(IMG_H - 1);
  // odd x always lies inside the pooled extent, so trailing odd column/row need no special case
  assign emit = accept && x[0] && y[0];
  assign pair = (DATA_W+1)'(pool_combine(mode_q, POOL_CW'(signed'(hold)), POOL_CW'(signed'(in_data))));
  assign vsum = pool_combine(mode_q, POOL_CW'(signed'(lb_rd)), POOL_CW'(signed'(pair)));
  assign busy = state == RUN;
  assign done = state == DONE;

  pool_line_buffer #(.DEPTH(DEPTH), .WIDTH(DATA_W + 1), .AW(AW)) u_lb (
    .clk(clk),
    .we(accept && x[0] && !y[0]),
    .waddr(AW'(x >> 1)),
    .wdata(pair),
    .raddr(AW'(x >> 1)),
    .rdata(lb_rd)
  );

  always_comb begin
    state_d = state;
    if (state == IDLE && start) state_d = RUN;
    if (state == RUN && in_done && (!out_valid || out_ready)) state_d = DONE;
    if (state == DONE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      mode_q <= POOL_MAX;
      x <= '0;
      y <= '0;
      in_done <= 1'b0;
      hold <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        mode_q <= pool_mode_e'(mode);
        x <= '0;
        y <= '0;
        in_done <= 1'b0;
      end else if (accept) begin
        x <= x_last ? '0 : x + XW'(1);
        if (x_last) y <= y_last ? '0 : y + YW'(1);
        if (x_last && y_last) in_done <= 1'b1;
        if (!x[0]) hold <= in_data;
      end
      if (emit) begin
        out_data <= DATA_W'(mode_q == POOL_AVG ? vsum >>> 2 : vsum);
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: randomized scoreboard bench over 4x4, 30x30 and 5x5 builds
`timescale 1ns/1ps
module tb_pool2x2_stream;
  logic clk = 0, rst = 0;
  logic [2:0] start = 0, mode = 0, in_valid = 0, out_ready = 0;
  logic [2:0] in_ready, out_valid, busy, done;
  logic [21:0] in_data [3];
  logic [21:0] out_data [3];
  longint exp_q[$];
  int pix[900];
  int n_cmp = 0, n_bad = 0;
  bit rnd_rdy = 0;

  always #5 clk = ~clk;

  pool2x2_stream #(.DATA_W(22), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]), .done(done[0]));
  pool2x2_stream #(.DATA_W(22), .IMG_W(30), .IMG_H(30)) u30 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]), .done(done[1]));
  pool2x2_stream #(.DATA_W(22), .IMG_W(5), .IMG_H(5)) u5 (
    .clk(clk), .rst(rst), .start(start[2]), .mode(mode[2]), .in_data(in_data[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .out_data(out_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .busy(busy[2]), .done(done[2]));

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: while a result is presented it must equal the queue head
  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      if (rst && out_valid[g]) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          check("out_data", longint'(signed'(out_data[g])), exp_q[0]);
          if (out_ready[g]) void'(exp_q.pop_front());
        end
      end

  initial forever begin
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) out_ready[g] = rnd_rdy ? ($urandom_range(1) == 1) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // reference: pooled windows straight from the frame, floor division for average
  function automatic void push_expected(input int w, input int h, input bit md);
    for (int oy = 0; oy < h / 2; oy++)
      for (int ox = 0; ox < w / 2; ox++) begin
        longint v[4], r, s;
        v[0] = pix[2*oy*w + 2*ox];
        v[1] = pix[2*oy*w + 2*ox + 1];
        v[2] = pix[(2*oy+1)*w + 2*ox];
        v[3] = pix[(2*oy+1)*w + 2*ox + 1];
        s = v[0] + v[1] + v[2] + v[3];
        r = v[0];
        for (int k = 1; k < 4; k++) if (v[k] > r) r = v[k];
        if (md) begin
          r = s / 4;
          if (s % 4 != 0 && s < 0) r = r - 1;
        end
        exp_q.push_back(r);
      end
  endfunction

  task automatic run_frame(input int g, input int w, input int h, input bit md,
                           input int gap_pct, input int abort_at, input int poke_at);
    int b;
    push_expected(w, h, md);
    @(posedge clk); #1;
    start[g] = 1; mode[g] = md;
    @(posedge clk); #1;
    start[g] = 0;
    for (int i = 0; i < w * h; i++) begin
      if (i == abort_at) begin
        rst = 0;
        #1;
        check("abort_out_valid", out_valid[g], 0);
        check("abort_busy", busy[g], 0);
        check("abort_in_ready", in_ready[g], 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1;
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        in_valid[g] = 0;
        @(posedge clk); #1;
      end
      in_valid[g] = 1;
      in_data[g] = 22'(pix[i]);
      if (i == poke_at) begin
        start[g] = 1;
        mode[g] = !md;
      end
      b = 0;
      forever begin
        @(negedge clk);
        if (in_ready[g]) break;
        @(posedge clk); #1;
        if (++b > 1000) begin
          check("in_ready_timeout", 0, 1);
          break;
        end
      end
      @(posedge clk); #1;
      in_valid[g] = 0;
      start[g] = 0;
    end
    b = 0;
    while (!done[g] && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("done_seen", done[g], 1);
    check("busy_in_done", busy[g], 0);
    @(negedge clk);
    check("done_one_cycle", done[g], 0);
    check("busy_after_done", busy[g], 0);
    check("all_results_out", exp_q.size(), 0);
  endtask

  function automatic int rnd_pix();
    return int'($urandom_range(22'h3fffff)) - (1 << 21);
  endfunction

  function automatic int extreme_pix();
    int e[4] = '{-(1 << 21), (1 << 21) - 1, -(1 << 21) + 1, (1 << 21) - 2};
    return $urandom_range(3) == 0 ? rnd_pix() : e[$urandom_range(3)];
  endfunction

  initial begin
    int t[16] = '{-1, -2, 3, 4, -3, -2, 5, 8, -1, -1, 7, 7, -1, 0, 7, 6};
    for (int g = 0; g < 3; g++) in_data[g] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check("rst_out_valid", out_valid[g], 0);
      check("rst_out_data", out_data[g], 0);
      check("rst_in_ready", in_ready[g], 0);
      check("rst_busy", busy[g], 0);
      check("rst_done", done[g], 0);
    end
    rst = 1;
    for (int i = 0; i < 16; i++) pix[i] = i;
    run_frame(0, 4, 4, 0, 0, -1, -1);
    for (int i = 0; i < 16; i++) pix[i] = t[i];
    run_frame(0, 4, 4, 1, 0, -1, -1);
    for (int i = 0; i < 900; i++) pix[i] = extreme_pix();
    run_frame(1, 30, 30, 0, 0, -1, -1);
    rnd_rdy = 1;
    for (int i = 0; i < 900; i++) pix[i] = rnd_pix();
    run_frame(1, 30, 30, 1, 30, -1, -1);
    for (int i = 0; i < 25; i++) pix[i] = rnd_pix();
    run_frame(2, 5, 5, 0, 20, -1, -1);
    for (int i = 0; i < 25; i++) pix[i] = rnd_pix();
    run_frame(2, 5, 5, 1, 20, -1, -1);
    rnd_rdy = 0;
    for (int i = 0; i < 16; i++) pix[i] = rnd_pix();
    run_frame(0, 4, 4, 0, 0, 10, -1);
    for (int i = 0; i < 16; i++) pix[i] = rnd_pix();
    run_frame(0, 4, 4, 1, 0, -1, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
